// File: rtl/cpu_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encodings, NOP control bits and
// the per-cycle control word driven onto the pipeline registers.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control bits an instruction carries down the pipe; a bubble zeroes them all.
  typedef struct packed {
    logic wreg;
    logic m2reg;
    logic wmem;
    logic branch;
  } insn_ctrl_t;

  localparam insn_ctrl_t NOP_CTRL = '0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idexe_bubble;
    logic flush_ifid;
    logic flush_exemem;
    logic pc_sel_branch;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN   = '{pc_en: 1'b1, ifid_en: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_STALL = '{idexe_bubble: 1'b1, default: 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH = '{default: 1'b1};

  // An older writer hits the ID instruction if it writes a real register that ID reads.
  function automatic logic raw_hit(input logic wreg, input logic [4:0] rd,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic use_rs, input logic use_rt);
    return wreg && (rd != REG_ZERO) &&
           ((use_rs && (rd == rs)) || (use_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard detection between the ID instruction and the EXE/MEM writers.
// WB is excluded: the register file writes before it reads within a cycle.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic       d_use_rs,
  input  logic       d_use_rt,
  input  logic       ewreg,
  input  logic [4:0] erdrt,
  input  logic       mwreg,
  input  logic [4:0] mrdrt,
  output logic       hazard
);

  logic haz_e, haz_m;

  always_comb begin
    haz_e  = raw_hit(ewreg, erdrt, d_rs, d_rt, d_use_rs, d_use_rt);
    haz_m  = raw_hit(mwreg, mrdrt, d_rs, d_rt, d_use_rs, d_use_rt);
    hazard = haz_e | haz_m;
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use stalls, MEM-stage
// branch flushes, saturating perf counters and a sticky stall watchdog.
module hazard_stall_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             ewreg,
  input  logic [4:0]       erdrt,
  input  logic             mwreg,
  input  logic [4:0]       mrdrt,
  input  logic             mbranch,
  input  logic             mzero,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idexe_bubble,
  output logic             flush_ifid,
  output logic             flush_exemem,
  output logic             pc_sel_branch,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic             stall_err,
  output logic [1:0]       state_dbg
);

  localparam int SCW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [SCW-1:0] STALL_LIM = SCW'(MAX_STALL);

  state_e     state, state_nxt;
  pipe_ctrl_t ctrl;
  logic       hazard, taken, stall;
  logic [SCW-1:0] stall_cnt;

  hazard_detect u_hazard_detect (
    .d_rs     (d_rs),
    .d_rt     (d_rt),
    .d_use_rs (d_use_rs),
    .d_use_rt (d_use_rt),
    .ewreg    (ewreg),
    .erdrt    (erdrt),
    .mwreg    (mwreg),
    .mrdrt    (mrdrt),
    .hazard   (hazard)
  );

  // A taken branch squashes the EXE writer, so it outranks any hazard.
  always_comb begin
    taken     = mbranch & mzero & ~rst;
    stall     = ~rst & ~taken & hazard & (state != FLUSH);
    ctrl      = CTRL_RUN;
    state_nxt = state;
    if (taken)      ctrl = CTRL_FLUSH;
    else if (stall) ctrl = CTRL_STALL;
    unique case (state)
      RUN, STALL: state_nxt = taken ? FLUSH : (hazard ? STALL : RUN);
      FLUSH:      state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  assign pc_en         = ctrl.pc_en;
  assign ifid_en       = ctrl.ifid_en;
  assign idexe_bubble  = ctrl.idexe_bubble;
  assign flush_ifid    = ctrl.flush_ifid;
  assign flush_exemem  = ctrl.flush_exemem;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      stall_cnt    <= '0;
      stall_err    <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_nxt;
      if (stall) begin
        if (stall_cnt == STALL_LIM) stall_err <= 1'b1;
        else                        stall_cnt <= stall_cnt + 1'b1;
        if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
      if (taken && flush_events != '1) flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: the driver pushes model expectations per cycle, a monitor
// pops and compares on the falling edge.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;
  localparam int MAX_STALL = 3;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] d_rs, d_rt, erdrt, mrdrt;
  logic d_use_rs, d_use_rt, ewreg, mwreg, mbranch, mzero;
  logic pc_en, ifid_en, idexe_bubble, flush_ifid, flush_exemem, pc_sel_branch;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic stall_err;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs),
    .d_use_rt(d_use_rt), .ewreg(ewreg), .erdrt(erdrt), .mwreg(mwreg),
    .mrdrt(mrdrt), .mbranch(mbranch), .mzero(mzero), .pc_en(pc_en),
    .ifid_en(ifid_en), .idexe_bubble(idexe_bubble), .flush_ifid(flush_ifid),
    .flush_exemem(flush_exemem), .pc_sel_branch(pc_sel_branch),
    .stall_cycles(stall_cycles), .flush_events(flush_events),
    .stall_err(stall_err), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [5:0] ctl;   // pc_en, ifid_en, bubble, flush_ifid, flush_exemem, pc_sel
    int sc, fe, err, st;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0, n_bad = 0;

  // Reference model state: pipeline mode (0 run, 1 stall, 2 flush), counters.
  int m_st = 0, m_run = 0, m_sc = 0, m_fe = 0, m_err = 0;

  function automatic bit writes_hit(bit w, int rd, int rs, int rt, bit urs, bit urt);
    if (!w || rd == 0) return 0;
    return (urs && rd == rs) || (urt && rd == rt);
  endfunction

  task automatic step(input string tag, input bit r, input int rs, input int rt,
                      input bit urs, input bit urt, input bit ew, input int erd,
                      input bit mw, input int mrd, input bit br, input bit z);
    exp_t e;
    bit hz, tk, stl;
    rst = r; d_rs = 5'(rs); d_rt = 5'(rt); d_use_rs = urs; d_use_rt = urt;
    ewreg = ew; erdrt = 5'(erd); mwreg = mw; mrdrt = 5'(mrd); mbranch = br; mzero = z;
    hz  = writes_hit(ew, erd, rs, rt, urs, urt) || writes_hit(mw, mrd, rs, rt, urs, urt);
    tk  = !r && br && z;
    stl = !r && !tk && hz && m_st != 2;
    if (tk)       e.ctl = 6'b111111;
    else if (stl) e.ctl = 6'b001000;
    else          e.ctl = 6'b110000;
    e.sc = m_sc; e.fe = m_fe; e.err = m_err; e.st = m_st; e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    if (r) begin
      m_st = 0; m_run = 0; m_sc = 0; m_fe = 0; m_err = 0;
    end else begin
      if (stl) begin
        if (m_run >= MAX_STALL) m_err = 1;
        m_run++;
        if (m_sc < CMAX) m_sc++;
      end else m_run = 0;
      if (tk && m_fe < CMAX) m_fe++;
      if (m_st == 2)   m_st = 0;
      else if (tk)     m_st = 2;
      else             m_st = hz ? 1 : 0;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever expectation is pending on each falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = sbq.pop_front();
      act = {pc_en, ifid_en, idexe_bubble, flush_ifid, flush_exemem, pc_sel_branch};
      n_vec++;
      if (act !== e.ctl || int'(stall_cycles) != e.sc || int'(flush_events) != e.fe ||
          int'(stall_err) != e.err || int'(state_dbg) != e.st) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b sc=%0d fe=%0d err=%0d st=%0d, need ctl=%b sc=%0d fe=%0d err=%0d st=%0d",
                 e.tag, act, stall_cycles, flush_events, stall_err, state_dbg,
                 e.ctl, e.sc, e.fe, e.err, e.st);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1; d_rs = '0; d_rt = '0; d_use_rs = 0; d_use_rt = 0; ewreg = 0;
    erdrt = '0; mwreg = 0; mrdrt = '0; mbranch = 0; mzero = 0;
    @(posedge clk); #1;
    // Reset cycle with hazard and taken presented: outputs must stay RUN-like.
    step("rst_mask", 1, 5, 0, 1, 0, 1, 5, 0, 0, 1, 1);
    step("rst_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use via EXE, then via MEM, then release.
    step("lu_exe", 0, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0);
    step("lu_mem", 0, 5, 0, 1, 0, 0, 0, 1, 5, 0, 0);
    idle("lu_done");
    idle("lu_after");
    // $0 writer never stalls.
    step("zero_wr", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    step("rt_hit", 0, 1, 7, 0, 1, 1, 7, 0, 0, 0, 0);
    step("rt_unused", 0, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0);
    // Taken branch, not-taken branch.
    step("br_taken", 0, 1, 2, 1, 1, 0, 0, 0, 0, 1, 1);
    step("br_flush", 0, 3, 0, 1, 0, 1, 3, 0, 0, 0, 0);
    idle("br_run");
    step("br_nt", 0, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
    // Branch arriving while stalled.
    step("stl_a", 0, 4, 0, 1, 0, 1, 4, 0, 0, 0, 0);
    step("stl_br", 0, 4, 0, 1, 0, 1, 4, 0, 0, 1, 1);
    idle("stl_br_fl");
    idle("stl_br_run");
    // Watchdog: five hazard cycles, then clear, then reset.
    for (int i = 0; i < 5; i++) step("wdog", 0, 9, 0, 1, 0, 0, 0, 1, 9, 0, 0);
    idle("wdog_clr");
    idle("wdog_hold");
    step("wdog_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("wdog_post");
    // Saturation: 20 taken branches.
    for (int i = 0; i < 20; i++) begin
      step("sat_br", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle("sat_gap");
    end
    // Randomized traffic over a small register window to hit hazards often.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 49) == 0),
           $urandom_range(0, 3), $urandom_range(0, 3),
           1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
           1'($urandom), $urandom_range(0, 3),
           ($urandom_range(0, 5) == 0), 1'($urandom));
    end
    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(posedge clk); guard++;
    end
    if (sbq.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, need 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
